// File: rtl/nvram_bridge_io_if.sv
// nvram_bridge_io_if: APF data-slot bridge word bus (write, read, overrun) between APF logic and the nvram bridge
interface nvram_bridge_io_if #(
    parameter int ADDR_WIDTH = 25
);
    logic                  br_wr_valid;
    logic                  br_wr_ready;
    logic [ADDR_WIDTH-1:0] br_wr_addr;
    logic [31:0]           br_wr_data;
    logic                  br_rd_req;
    logic [ADDR_WIDTH-1:0] br_rd_addr;
    logic [31:0]           br_rd_data;
    logic                  br_rd_valid;
    logic                  rd_overrun;

    modport master (
        output br_wr_valid, br_wr_addr, br_wr_data, br_rd_req, br_rd_addr,
        input  br_wr_ready, br_rd_data, br_rd_valid, rd_overrun
    );

    modport slave (
        input  br_wr_valid, br_wr_addr, br_wr_data, br_rd_req, br_rd_addr,
        output br_wr_ready, br_rd_data, br_rd_valid, rd_overrun
    );
endinterface

// File: rtl/nvram_bridge_io.sv
// nvram_bridge_io: serialises bridge words into ioctl bytes, packs ioctl bytes into bridge read words, forwards autosave requests
module nvram_bridge_io #(
    parameter int         ADDR_WIDTH  = 25,
    parameter logic [7:0] IOCTL_INDEX = 8'd3,
    parameter int         RD_LATENCY  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_dl_active,
    input  logic                  i_ul_active,
    nvram_bridge_io_if.slave      br,
    output logic                  o_ioctl_download,
    output logic                  o_ioctl_upload,
    output logic                  o_ioctl_wr,
    output logic [ADDR_WIDTH-1:0] o_ioctl_addr,
    output logic [7:0]            o_ioctl_index,
    output logic [7:0]            o_ioctl_dout,
    input  logic [7:0]            i_ioctl_din,
    input  logic                  i_upload_req,
    output logic                  o_save_req,
    input  logic                  i_save_ack
);
    typedef enum logic [2:0] {S_IDLE, S_WR_BYTE, S_RD_SET, S_RD_WAIT, S_RD_DONE} state_t;

    localparam logic [2:0]            LAST_WAIT = 3'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(3);

    state_t                r_state, w_next;
    logic                  r_run, r_pend, r_dl, r_ul, r_up_d, r_save;
    logic [1:0]            r_k;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_base, r_pend_base;
    logic [31:0]           r_wdata, r_rdata;
    logic                  w_rd_in, w_wait_done, w_wr_go, w_rd_go, w_rd_from_pend;
    logic                  w_pend_set, w_pend_clr, w_overrun;

    assign w_rd_in     = br.br_rd_req && i_ul_active;
    assign w_wait_done = (r_state == S_RD_WAIT) && (r_cnt == LAST_WAIT);

    assign br.br_wr_ready  = (r_state == S_IDLE) && r_run;
    assign br.br_rd_valid  = r_state == S_RD_DONE;
    assign br.br_rd_data   = r_rdata;
    assign br.rd_overrun   = w_overrun;
    assign o_ioctl_wr      = r_state == S_WR_BYTE;
    assign o_ioctl_addr    = (r_state inside {S_WR_BYTE, S_RD_SET, S_RD_WAIT}) ? r_base + ADDR_WIDTH'(r_k) : '0;
    assign o_ioctl_dout    = o_ioctl_wr ? r_wdata[31:24] : 8'd0;
    assign o_ioctl_index   = IOCTL_INDEX;
    assign o_ioctl_download = r_dl;
    assign o_ioctl_upload  = r_ul && !r_dl;
    assign o_save_req      = r_save;

    // state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // next state, transaction starts and pending-slot control; writes outrank reads in IDLE
    always_comb begin
        w_next         = r_state;
        w_wr_go        = 1'b0;
        w_rd_go        = 1'b0;
        w_rd_from_pend = 1'b0;
        w_pend_set     = 1'b0;
        w_pend_clr     = 1'b0;
        w_overrun      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_run && br.br_wr_valid && i_dl_active) begin
                    w_next     = S_WR_BYTE;
                    w_wr_go    = 1'b1;
                    w_pend_set = w_rd_in && !r_pend;
                    w_overrun  = w_rd_in && r_pend;
                end else if (r_pend) begin
                    w_next         = S_RD_SET;
                    w_rd_go        = 1'b1;
                    w_rd_from_pend = 1'b1;
                    w_pend_clr     = 1'b1;
                    w_pend_set     = w_rd_in;
                end else if (w_rd_in) begin
                    w_next  = S_RD_SET;
                    w_rd_go = 1'b1;
                end
            end
            S_WR_BYTE: w_next = (r_k == 2'd3) ? S_IDLE : S_WR_BYTE;
            S_RD_SET:  w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = !w_wait_done ? S_RD_WAIT : (r_k == 2'd3) ? S_RD_DONE : S_RD_SET;
            S_RD_DONE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE) begin
            w_pend_set = w_rd_in && !r_pend;
            w_overrun  = w_rd_in && r_pend;
        end
    end

    // byte lane counter, wait counter, base address and data shift registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_run   <= 1'b0;
            r_k     <= 2'd0;
            r_cnt   <= 3'd0;
            r_base  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_run   <= 1'b1;
            r_k     <= (w_wr_go || w_rd_go) ? 2'd0 : (o_ioctl_wr || w_wait_done) ? r_k + 2'd1 : r_k;
            r_cnt   <= (r_state == S_RD_WAIT && !w_wait_done) ? r_cnt + 3'd1 : 3'd0;
            r_base  <= w_wr_go ? br.br_wr_addr & ~LANE_MASK :
                       !w_rd_go ? r_base :
                       w_rd_from_pend ? r_pend_base : br.br_rd_addr & ~LANE_MASK;
            r_wdata <= w_wr_go ? br.br_wr_data : o_ioctl_wr ? r_wdata << 8 : r_wdata;
            r_rdata <= w_wait_done ? {r_rdata[23:0], i_ioctl_din} : r_rdata;
        end
    end

    // one-deep slot holding a read that arrived while busy
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend      <= 1'b0;
            r_pend_base <= '0;
        end else begin
            r_pend      <= w_pend_set || (r_pend && !w_pend_clr);
            r_pend_base <= w_pend_set ? br.br_rd_addr & ~LANE_MASK : r_pend_base;
        end
    end

    // download/upload levels, download stretched to the end of a running burst; save request latch
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dl   <= 1'b0;
            r_ul   <= 1'b0;
            r_up_d <= 1'b0;
            r_save <= 1'b0;
        end else begin
            r_dl   <= i_dl_active || (o_ioctl_wr && r_k != 2'd3);
            r_ul   <= i_ul_active;
            r_up_d <= i_upload_req;
            r_save <= r_save ? !i_save_ack : (i_upload_req && !r_up_d);
        end
    end
endmodule

// File: tb/tb_nvram_bridge_io.sv
// tb_nvram_bridge_io: randomized scenario bench with an nvram read model and spec-level expectations
module tb_nvram_bridge_io;
    localparam int AW  = 25;
    localparam int LAT = 2;
    localparam int RD_LAT_CYC = 4 * (LAT + 1) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dl = 1'b0, ul = 1'b0, up = 1'b0, ack = 1'b0;
    logic [7:0]    din;
    logic          ioctl_download, ioctl_upload, ioctl_wr, save_req;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_index, ioctl_dout;
    int            n_checks = 0, n_fail = 0, cyc = 0, ovr_n = 0;

    typedef struct {int c; logic [AW-1:0] a; logic [7:0] d; logic dl;} wr_t;
    typedef struct {int c; logic [31:0] d;} rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    nvram_bridge_io_if #(.ADDR_WIDTH(AW)) bif();

    nvram_bridge_io #(.ADDR_WIDTH(AW), .IOCTL_INDEX(8'd3), .RD_LATENCY(LAT)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_dl_active(dl), .i_ul_active(ul), .br(bif),
        .o_ioctl_download(ioctl_download), .o_ioctl_upload(ioctl_upload), .o_ioctl_wr(ioctl_wr),
        .o_ioctl_addr(ioctl_addr), .o_ioctl_index(ioctl_index), .o_ioctl_dout(ioctl_dout),
        .i_ioctl_din(din), .i_upload_req(up), .o_save_req(save_req), .i_save_ack(ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] nv_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = a & ~AW'(3);
        return {nv_byte(b), nv_byte(b + AW'(1)), nv_byte(b + AW'(2)), nv_byte(b + AW'(3))};
    endfunction

    logic [AW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= ioctl_addr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign din = nv_byte(pipe[LAT-1]);

    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (ioctl_wr) begin
            w.c = cyc; w.a = ioctl_addr; w.d = ioctl_dout; w.dl = ioctl_download;
            wr_q.push_back(w);
        end
        if (bif.br_rd_valid) begin
            r.c = cyc; r.d = bif.br_rd_data;
            rd_q.push_back(r);
        end
        if (bif.rd_overrun) ovr_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        int t = 0;
        bif.br_wr_valid = 1'b1; bif.br_wr_addr = a; bif.br_wr_data = d;
        @(negedge clk);
        while (bif.br_wr_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        n_checks++;
        if (bif.br_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL write_accept: ready=%b, required 1 within 40 cycles", bif.br_wr_ready);
        end
        @(posedge clk); #1;
        bif.br_wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int rc);
        bif.br_rd_req = 1'b1; bif.br_rd_addr = a; rc = cyc;
        tick(1);
        bif.br_rd_req = 1'b0;
    endtask

    task automatic wait_read(input int base);
        int t = 0;
        while (rd_q.size() <= base && t < 40) begin tick(1); t++; end
    endtask

    task automatic test_reset();
        logic [79:0] obs;
        dl = 1'b1; ul = 1'b1; up = 1'b1;
        tick(3);
        obs = {bif.br_wr_ready, bif.br_rd_valid, bif.rd_overrun, bif.br_rd_data, ioctl_download, ioctl_upload,
               ioctl_wr, ioctl_addr, ioctl_dout, save_req, ioctl_index};
        n_checks++;
        if (obs !== {3'b0, 32'h0, 3'b0, AW'(0), 8'h0, 1'b0, 8'd3}) begin
            n_fail++; $display("FAIL reset_outputs: got %h, required %h", obs, {3'b0, 32'h0, 3'b0, AW'(0), 8'h0, 1'b0, 8'd3});
        end
        dl = 1'b0; ul = 1'b0; up = 1'b0;
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (bif.br_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b, required 1", bif.br_wr_ready);
        end
    endtask

    task automatic test_write();
        logic [AW-1:0] a [5];
        logic [31:0]   d [5];
        logic [AW-1:0] ea;
        logic [31:0]   sh;
        int base;
        a[0] = AW'(8); d[0] = 32'h1122_3344;
        a[1] = '1;     d[1] = $urandom;
        for (int i = 2; i < 5; i++) begin a[i] = AW'($urandom); d[i] = $urandom; end
        dl = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            base = wr_q.size();
            do_write(a[i], d[i]);
            tick(6);
            n_checks++;
            if (wr_q.size() != base + 4) begin
                n_fail++; $display("FAIL write_count[%0d]: got %0d bytes, required 4", i, wr_q.size() - base);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    ea = (a[i] & ~AW'(3)) + AW'(k);
                    sh = d[i] >> (24 - 8 * k);
                    n_checks++;
                    if (wr_q[base+k].a !== ea || wr_q[base+k].d !== sh[7:0] || wr_q[base+k].dl !== 1'b1 ||
                        wr_q[base+k].c !== wr_q[base].c + k) begin
                        n_fail++;
                        $display("FAIL write_byte[%0d][%0d]: addr=%h dout=%h dl=%b cyc+%0d, required addr=%h dout=%h dl=1 cyc+%0d",
                                 i, k, wr_q[base+k].a, wr_q[base+k].d, wr_q[base+k].dl, wr_q[base+k].c - wr_q[base].c, ea, sh[7:0], k);
                    end
                end
            end
        end
        dl = 1'b0;
        tick(2);
        base = wr_q.size();
        do_write(AW'($urandom), $urandom);
        tick(6);
        n_checks++;
        if (wr_q.size() != base) begin
            n_fail++; $display("FAIL write_no_download: got %0d ioctl_wr, required 0", wr_q.size() - base);
        end
    endtask

    task automatic test_read();
        logic [AW-1:0] a [5];
        int base, rc;
        a[0] = AW'(4); a[1] = '1;
        for (int i = 2; i < 5; i++) a[i] = AW'($urandom);
        dl = 1'b0; ul = 1'b1;
        tick(3);
        n_checks++;
        if (ioctl_upload !== 1'b1) begin
            n_fail++; $display("FAIL upload_level: got %b, required 1", ioctl_upload);
        end
        for (int i = 0; i < 5; i++) begin
            base = rd_q.size();
            do_read(a[i], rc);
            wait_read(base);
            n_checks++;
            if (rd_q.size() <= base) begin
                n_fail++; $display("FAIL read_timeout[%0d]: no br_rd_valid, required one", i);
            end else if (rd_q[base].d !== exp_word(a[i]) || rd_q[base].c !== rc + RD_LAT_CYC) begin
                n_fail++;
                $display("FAIL read[%0d]: data=%h latency=%0d, required data=%h latency=%0d",
                         i, rd_q[base].d, rd_q[base].c - rc, exp_word(a[i]), RD_LAT_CYC);
            end
        end
        ul = 1'b0;
        tick(1);
        base = rd_q.size();
        do_read(AW'($urandom), rc);
        tick(20);
        n_checks++;
        if (rd_q.size() != base) begin
            n_fail++; $display("FAIL read_no_upload: got %0d br_rd_valid, required 0", rd_q.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, a2, wa;
        logic [31:0]   wd, sh;
        int wb, rb, ob;
        a1 = AW'($urandom); a2 = AW'($urandom); wa = AW'($urandom); wd = $urandom;
        dl = 1'b1; ul = 1'b1;
        tick(3);
        wb = wr_q.size(); rb = rd_q.size(); ob = ovr_n;
        bif.br_wr_valid = 1'b1; bif.br_wr_addr = wa; bif.br_wr_data = wd;
        bif.br_rd_req = 1'b1; bif.br_rd_addr = a1;
        @(negedge clk);
        n_checks++;
        if (bif.br_wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b, required 1", bif.br_wr_ready);
        end
        @(posedge clk); #1;
        bif.br_wr_valid = 1'b0; bif.br_rd_addr = a2;
        @(negedge clk);
        n_checks++;
        if (bif.rd_overrun !== 1'b1) begin
            n_fail++; $display("FAIL b2b_overrun_pulse: got %b, required 1", bif.rd_overrun);
        end
        @(posedge clk); #1;
        bif.br_rd_req = 1'b0;
        wait_read(rb);
        tick(20);
        n_checks++;
        if (wr_q.size() != wb + 4) begin
            n_fail++; $display("FAIL b2b_write_count: got %0d, required 4", wr_q.size() - wb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                sh = wd >> (24 - 8 * k);
                n_checks++;
                if (wr_q[wb+k].a !== (wa & ~AW'(3)) + AW'(k) || wr_q[wb+k].d !== sh[7:0]) begin
                    n_fail++; $display("FAIL b2b_write_byte[%0d]: addr=%h dout=%h, required addr=%h dout=%h",
                                       k, wr_q[wb+k].a, wr_q[wb+k].d, (wa & ~AW'(3)) + AW'(k), sh[7:0]);
                end
            end
        end
        n_checks++;
        if (rd_q.size() != rb + 1) begin
            n_fail++; $display("FAIL b2b_read_count: got %0d, required 1", rd_q.size() - rb);
        end else if (rd_q[rb].d !== exp_word(a1) || (wr_q.size() >= wb + 4 && rd_q[rb].c <= wr_q[wb+3].c)) begin
            n_fail++; $display("FAIL b2b_read: data=%h, required %h after the last write byte", rd_q[rb].d, exp_word(a1));
        end
        n_checks++;
        if (ovr_n - ob != 1) begin
            n_fail++; $display("FAIL b2b_overrun_count: got %0d, required 1", ovr_n - ob);
        end
        dl = 1'b0; ul = 1'b0;
        tick(2);
    endtask

    task automatic test_dl_fall();
        logic [AW-1:0] a;
        logic [31:0]   d, sh;
        a = AW'($urandom); d = $urandom;
        dl = 1'b1; ul = 1'b1;
        tick(3);
        do_write(a, d);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) dl = 1'b0;
            @(negedge clk);
            sh = d >> (24 - 8 * k);
            n_checks++;
            if ({ioctl_wr, ioctl_download, ioctl_upload, ioctl_addr, ioctl_dout} !== {3'b110, (a & ~AW'(3)) + AW'(k), sh[7:0]}) begin
                n_fail++; $display("FAIL dl_fall_byte[%0d]: wr/dl/ul=%b%b%b addr=%h dout=%h, required 110 addr=%h dout=%h",
                                   k, ioctl_wr, ioctl_download, ioctl_upload, ioctl_addr, ioctl_dout, (a & ~AW'(3)) + AW'(k), sh[7:0]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if ({ioctl_wr, ioctl_download} !== 2'b00) begin
            n_fail++; $display("FAIL dl_fall_drop: wr/dl=%b%b, required 00", ioctl_wr, ioctl_download);
        end
        ul = 1'b0;
        tick(2);
    endtask

    task automatic test_save();
        logic m, upp, nu, na;
        up = 1'b0; ack = 1'b0;
        tick(2);
        up = 1'b1; tick(1);
        n_checks++;
        if (save_req !== 1'b1) begin n_fail++; $display("FAIL save_set: got %b, required 1", save_req); end
        up = 1'b0; tick(1);
        up = 1'b1; tick(1);
        n_checks++;
        if (save_req !== 1'b1) begin n_fail++; $display("FAIL save_merge: got %b, required 1", save_req); end
        ack = 1'b1; tick(1);
        n_checks++;
        if (save_req !== 1'b0) begin n_fail++; $display("FAIL save_clear: got %b, required 0", save_req); end
        ack = 1'b0; tick(3);
        n_checks++;
        if (save_req !== 1'b0) begin n_fail++; $display("FAIL save_single_ack: got %b, required 0", save_req); end
        m = 1'b0; upp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            nu = 1'($urandom_range(0, 1));
            na = ($urandom_range(0, 3) == 0);
            up = nu; ack = na;
            tick(1);
            m = m ? !na : (nu && !upp);
            upp = nu;
            n_checks++;
            if (save_req !== m) begin
                n_fail++; $display("FAIL save_random[%0d]: got %b, required %b", i, save_req, m);
            end
        end
        up = 1'b0; ack = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_read();
        logic [79:0]   obs;
        logic [AW-1:0] a;
        int rb, rc;
        dl = 1'b0; ul = 1'b1;
        tick(2);
        rb = rd_q.size();
        do_read(AW'($urandom) | AW'(1), rc);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        obs = {bif.br_wr_ready, bif.br_rd_valid, bif.rd_overrun, bif.br_rd_data, ioctl_download, ioctl_upload,
               ioctl_wr, ioctl_addr, ioctl_dout, save_req, ioctl_index};
        n_checks++;
        if (obs !== {3'b0, 32'h0, 3'b0, AW'(0), 8'h0, 1'b0, 8'd3}) begin
            n_fail++; $display("FAIL mid_read_reset: got %h, required %h", obs, {3'b0, 32'h0, 3'b0, AW'(0), 8'h0, 1'b0, 8'd3});
        end
        tick(2);
        rst_n = 1'b1;
        tick(20);
        n_checks++;
        if (rd_q.size() != rb) begin
            n_fail++; $display("FAIL mid_read_stale: got %0d br_rd_valid, required 0", rd_q.size() - rb);
        end
        a = AW'($urandom);
        do_read(a, rc);
        wait_read(rb);
        n_checks++;
        if (rd_q.size() <= rb) begin
            n_fail++; $display("FAIL post_reset_read_timeout: no br_rd_valid, required one");
        end else if (rd_q[rb].d !== exp_word(a) || rd_q[rb].c !== rc + RD_LAT_CYC) begin
            n_fail++; $display("FAIL post_reset_read: data=%h latency=%0d, required data=%h latency=%0d",
                               rd_q[rb].d, rd_q[rb].c - rc, exp_word(a), RD_LAT_CYC);
        end
        ul = 1'b0;
    endtask

    initial begin
        bif.br_wr_valid = 1'b0; bif.br_wr_addr = '0; bif.br_wr_data = '0;
        bif.br_rd_req = 1'b0;   bif.br_rd_addr = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_dl_fall();
        test_save();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000, required completion");
        $fatal(1);
    end
endmodule
